// File: rtl/mem_port_arbiter_pkg.sv
// Shared parameters and types for the memory port arbiter: default widths,
// FSM state encodings, the transaction owner type and a counter-width helper.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_DEF       = 32;
    localparam int unsigned W_OPR_DEF      = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StBusy = ST_BUSY,
        StResp = ST_RESP
    } arb_state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnEx = 1'b1
    } arb_owner_e;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int unsigned ctr_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard: counts execute grants taken while fetch is waiting
// and raises o_force_if once STARVE_MAX consecutive wins have gone to execute.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_if_req,
    input  logic i_if_gnt,
    input  logic i_ex_gnt,
    output logic o_force_if
);

    localparam int unsigned CW = ctr_width(STARVE_MAX);
    localparam logic [CW-1:0] MAX_CNT = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;

    // Count execute wins over a waiting fetch; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_if_gnt || !i_if_req) begin
            r_cnt <= '0;
        end else if (i_ex_gnt && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_force_if = (r_cnt >= MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port arbiter between instruction fetch and the
// execute stage. Execute has priority; define ARB_STARVE_GUARD_EN to hand a
// contested slot to fetch after STARVE_MAX consecutive execute wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR       = ADDR_DEF,
    parameter int unsigned W_OPR      = W_OPR_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req_i,
    input  logic [ADDR-1:0]  if_addr_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [W_OPR-1:0] if_rdata_o,
    input  logic             ex_req_i,
    input  logic             ex_write_i,
    input  logic [ADDR-1:0]  ex_addr_i,
    input  logic [W_OPR-1:0] ex_wdata_i,
    output logic             ex_gnt_o,
    output logic             ex_rvalid_o,
    output logic [W_OPR-1:0] ex_rdata_o,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [ADDR-1:0]  mem_addr_o,
    output logic [W_OPR-1:0] mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [W_OPR-1:0] mem_rdata_i,
    output logic             stall_o,
    output logic             busy_o
);

    arb_state_e       r_state;
    arb_owner_e       r_owner;
    logic [ADDR-1:0]  r_addr;
    logic             r_write;
    logic [W_OPR-1:0] r_wdata;
    logic [W_OPR-1:0] r_if_rdata;
    logic [W_OPR-1:0] r_ex_rdata;

    logic w_arb_en;
    logic w_force_if;
    logic w_if_gnt;
    logic w_ex_gnt;
    logic w_busy;
    logic w_if_rvalid;
    logic w_ex_rvalid;

    // Grants are only offered from IDLE, and never while reset is held.
    assign w_arb_en = (r_state == StIdle) && reset;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_if_req   (if_req_i),
        .i_if_gnt   (w_if_gnt),
        .i_ex_gnt   (w_ex_gnt),
        .o_force_if (w_force_if)
    );
`else
    logic w_unused_starve_max;
    assign w_unused_starve_max = ^STARVE_MAX;
    assign w_force_if          = 1'b0;
`endif

    // Same-cycle arbitration: execute first unless the starvation guard forces fetch.
    always_comb begin
        w_if_gnt = 1'b0;
        w_ex_gnt = 1'b0;
        if (w_arb_en) begin
            if (ex_req_i && !(if_req_i && w_force_if)) begin
                w_ex_gnt = 1'b1;
            end else if (if_req_i) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    // Transaction FSM: latch the winner's request, wait for ack, then one response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_owner    <= OwnIf;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_ex_rdata <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_ex_gnt) begin
                        r_state <= StBusy;
                        r_owner <= OwnEx;
                        r_addr  <= ex_addr_i;
                        r_write <= ex_write_i;
                        r_wdata <= ex_wdata_i;
                    end else if (w_if_gnt) begin
                        r_state <= StBusy;
                        r_owner <= OwnIf;
                        r_addr  <= if_addr_i;
                        r_write <= 1'b0;
                        r_wdata <= '0;
                    end
                end
                StBusy: begin
                    if (mem_ack_i) begin
                        r_state <= StResp;
                        if (r_owner == OwnIf) begin
                            r_if_rdata <= mem_rdata_i;
                        end else if (!r_write) begin
                            r_ex_rdata <= mem_rdata_i;
                        end
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_busy      = (r_state != StIdle);
    assign w_if_rvalid = (r_state == StResp) && (r_owner == OwnIf);
    assign w_ex_rvalid = (r_state == StResp) && (r_owner == OwnEx);

    assign if_gnt_o    = w_if_gnt;
    assign ex_gnt_o    = w_ex_gnt;
    assign if_rvalid_o = w_if_rvalid;
    assign ex_rvalid_o = w_ex_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign ex_rdata_o  = r_ex_rdata;
    assign busy_o      = w_busy;

    assign mem_req_o   = (r_state == StBusy);
    assign mem_write_o = (r_state == StBusy) && r_write;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    // Execute stalls while its request waits, and while its own access is in flight.
    assign stall_o = (ex_req_i && !w_ex_gnt && reset) ||
                     (w_busy && (r_owner == OwnEx) && !w_ex_rvalid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them on each rvalid pulse.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ex_req_i;
    logic        ex_write_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_gnt_o;
    logic        ex_rvalid_o;
    logic [31:0] ex_rdata_o;
    logic        mem_req_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        busy_o;

    typedef struct packed {
        logic        is_ex;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ex_req_i    (ex_req_i),
        .ex_write_i  (ex_write_i),
        .ex_addr_i   (ex_addr_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_gnt_o    (ex_gnt_o),
        .ex_rvalid_o (ex_rvalid_o),
        .ex_rdata_o  (ex_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (if_rvalid_o || ex_rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {62'd0, if_rvalid_o, ex_rvalid_o}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_port", {62'd0, if_rvalid_o, ex_rvalid_o},
                      e.is_ex ? 64'd1 : 64'd2);
                check("rdata", e.is_ex ? {32'd0, ex_rdata_o} : {32'd0, if_rdata_o},
                      {32'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_if;
        reset       = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        ex_req_i    = 1'b1;
        ex_write_i  = 1'b0;
        ex_addr_i   = '0;
        ex_wdata_i  = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;

        // Reset state, with an execute request held to prove outputs stay quiet.
        repeat (2) sample();
        check("rst_ex_gnt", ex_gnt_o, 0);
        check("rst_if_gnt", if_gnt_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_if_rvalid", if_rvalid_o, 0);
        check("rst_ex_rvalid", ex_rvalid_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_ex_rdata", ex_rdata_o, 0);
        ex_req_i = 1'b0;
        reset    = 1'b1;
        next_cycle();

        // Fetch-only read of 0x100, ack in first BUSY cycle; an execute load queues behind it.
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        sample();
        check("rd_if_gnt", if_gnt_o, 1);
        check("rd_ex_gnt", ex_gnt_o, 0);
        check("rd_busy_t0", busy_o, 0);
        exp_q.push_back('{is_ex: 1'b0, data: 32'hDEAD_BEEF});
        next_cycle();
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        ex_req_i    = 1'b1;
        ex_addr_i   = 32'h500;
        sample();
        check("rd_mem_req_t1", mem_req_o, 1);
        check("rd_mem_addr_t1", mem_addr_o, 32'h100);
        check("rd_mem_write_t1", mem_write_o, 0);
        check("rd_busy_t1", busy_o, 1);
        check("wait_ex_gnt_busy", ex_gnt_o, 0);
        check("wait_stall_busy", stall_o, 1);
        next_cycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        sample();
        check("rd_if_rvalid_t2", if_rvalid_o, 1);
        check("rd_mem_req_t2", mem_req_o, 0);
        check("wait_ex_gnt_resp", ex_gnt_o, 0);
        check("wait_stall_resp", stall_o, 1);
        next_cycle();
        sample();
        check("wait_ex_gnt_idle", ex_gnt_o, 1);
        check("wait_stall_idle", stall_o, 0);
        check("rd_if_rvalid_gone", if_rvalid_o, 0);
        check("rd_if_rdata_hold", if_rdata_o, 32'hDEAD_BEEF);
        exp_q.push_back('{is_ex: 1'b1, data: 32'h5555_AAAA});
        next_cycle();
        ex_req_i    = 1'b0;
        ex_addr_i   = '0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_AAAA;
        sample();
        check("ld_mem_addr", mem_addr_o, 32'h500);
        check("ld_stall_busy", stall_o, 1);
        next_cycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        sample();
        check("ld_ex_rvalid", ex_rvalid_o, 1);
        check("ld_stall_resp", stall_o, 0);
        next_cycle();

        // Stray ack in IDLE must be ignored.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h9999_9999;
        sample();
        check("idle_ack_busy", busy_o, 0);
        check("idle_ack_mem_req", mem_req_o, 0);
        next_cycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        sample();
        check("idle_ack_busy2", busy_o, 0);
        check("idle_ack_rvalid", {if_rvalid_o, ex_rvalid_o}, 0);
        next_cycle();

        // Contention: execute wins, fetch follows right after RESP.
        if_req_i   = 1'b1;
        if_addr_i  = 32'h200;
        ex_req_i   = 1'b1;
        ex_addr_i  = 32'h300;
        ex_write_i = 1'b0;
        sample();
        check("ct_ex_gnt", ex_gnt_o, 1);
        check("ct_if_gnt", if_gnt_o, 0);
        check("ct_stall_gnt", stall_o, 0);
        exp_q.push_back('{is_ex: 1'b1, data: 32'hA5A5_0001});
        next_cycle();
        ex_req_i    = 1'b0;
        ex_addr_i   = '0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hA5A5_0001;
        sample();
        check("ct_if_gnt_busy", if_gnt_o, 0);
        check("ct_mem_addr_ex", mem_addr_o, 32'h300);
        check("ct_stall_busy", stall_o, 1);
        next_cycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        sample();
        check("ct_if_gnt_resp", if_gnt_o, 0);
        check("ct_ex_rvalid", ex_rvalid_o, 1);
        next_cycle();
        sample();
        check("ct_if_gnt_after", if_gnt_o, 1);
        exp_q.push_back('{is_ex: 1'b0, data: 32'h0BAD_F00D});
        next_cycle();
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0BAD_F00D;
        sample();
        check("ct_mem_addr_if", mem_addr_o, 32'h200);
        check("ct_mem_write_if", mem_write_o, 0);
        next_cycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        sample();
        check("ct_if_rvalid", if_rvalid_o, 1);
        next_cycle();

        // Store to 0x40, ack in third BUSY cycle; load data must be left alone.
        ex_req_i   = 1'b1;
        ex_write_i = 1'b1;
        ex_addr_i  = 32'h40;
        ex_wdata_i = 32'h1234_5678;
        sample();
        check("st_ex_gnt", ex_gnt_o, 1);
        exp_q.push_back('{is_ex: 1'b1, data: 32'hA5A5_0001});
        next_cycle();
        ex_req_i   = 1'b0;
        ex_write_i = 1'b0;
        ex_addr_i  = 32'hFFFF;
        ex_wdata_i = '0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hFFFF_FFFF;
            end
            sample();
            check("st_mem_req", mem_req_o, 1);
            check("st_mem_write", mem_write_o, 1);
            check("st_mem_addr", mem_addr_o, 32'h40);
            check("st_mem_wdata", mem_wdata_o, 32'h1234_5678);
            check("st_stall", stall_o, 1);
            next_cycle();
        end
        sample();
        check("st_ex_rvalid", ex_rvalid_o, 1);
        check("st_stall_resp", stall_o, 0);
        check("st_mem_write_resp", mem_write_o, 0);
        next_cycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        ex_addr_i   = '0;
        sample();
        check("st_busy_after", busy_o, 0);
        check("st_ex_rdata_hold", ex_rdata_o, 32'hA5A5_0001);
        next_cycle();

        // Reset in the middle of a fetch; a later ack must not produce a response.
        if_req_i  = 1'b1;
        if_addr_i = 32'h700;
        sample();
        check("mr_if_gnt", if_gnt_o, 1);
        next_cycle();
        if_req_i  = 1'b0;
        if_addr_i = '0;
        sample();
        check("mr_mem_req_pre", mem_req_o, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_mem_req", mem_req_o, 0);
        check("mr_busy", busy_o, 0);
        check("mr_mem_addr", mem_addr_o, 0);
        check("mr_if_rdata", if_rdata_o, 0);
        check("mr_ex_rdata", ex_rdata_o, 0);
        sample();
        reset       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            sample();
            check("mr_no_rvalid", {if_rvalid_o, ex_rvalid_o}, 0);
            check("mr_idle", busy_o, 0);
        end
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;

        // Both sides requesting continuously.
        next_cycle();
        if_req_i   = 1'b1;
        if_addr_i  = 32'h1000;
        ex_req_i   = 1'b1;
        ex_addr_i  = 32'h2000;
        ex_write_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
`ifdef ARB_STARVE_GUARD_EN
            exp_if = ((i % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            check("sv_if_gnt", if_gnt_o, exp_if);
            check("sv_ex_gnt", ex_gnt_o, !exp_if);
            exp_q.push_back('{is_ex: !exp_if, data: 32'hC000_0000 + 32'(i)});
            next_cycle();
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hC000_0000 + 32'(i);
            sample();
            check("sv_mem_addr", mem_addr_o, exp_if ? 32'h1000 : 32'h2000);
            next_cycle();
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            next_cycle();
        end
        if_req_i = 1'b0;
        ex_req_i = 1'b0;
        repeat (3) next_cycle();
        sample();
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
